// File: rtl/eeg_dwt_top.sv
// rtl/eeg_dwt_top.sv - streaming 4-level Haar DWT with per-band max/min/mean/sum over 128-sample windows
// Pipeline: coefficient capture on the accept edge, stat update one edge later, feature publish the edge after.
module eeg_dwt_top #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] preprocessed_input,
    output logic signed [DATA_W-1:0] dwt_gamma_max,
    output logic signed [DATA_W-1:0] dwt_gamma_min,
    output logic signed [DATA_W-1:0] dwt_gamma_mean,
    output logic signed [DATA_W-1:0] dwt_gamma_sum,
    output logic signed [DATA_W-1:0] dwt_beta_max,
    output logic signed [DATA_W-1:0] dwt_beta_min,
    output logic signed [DATA_W-1:0] dwt_beta_mean,
    output logic signed [DATA_W-1:0] dwt_beta_sum,
    output logic signed [DATA_W-1:0] dwt_alpha_max,
    output logic signed [DATA_W-1:0] dwt_alpha_min,
    output logic signed [DATA_W-1:0] dwt_alpha_mean,
    output logic signed [DATA_W-1:0] dwt_alpha_sum,
    output logic signed [DATA_W-1:0] dwt_theta_max,
    output logic signed [DATA_W-1:0] dwt_theta_min,
    output logic signed [DATA_W-1:0] dwt_theta_mean,
    output logic signed [DATA_W-1:0] dwt_theta_sum,
    output logic signed [DATA_W-1:0] dwt_delta_max,
    output logic signed [DATA_W-1:0] dwt_delta_min,
    output logic signed [DATA_W-1:0] dwt_delta_mean,
    output logic signed [DATA_W-1:0] dwt_delta_sum,
    output logic                     dwt_valid
);

    localparam int SW = DATA_W + 7;

    function automatic logic signed [DATA_W-1:0] f_avg(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return DATA_W'(s >>> 1);
    endfunction

    function automatic logic signed [DATA_W-1:0] f_dif(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return DATA_W'(s >>> 1);
    endfunction

    logic [6:0]               r_cnt;
    logic signed [DATA_W-1:0] r_h1, r_h2, r_h3, r_h4;
    logic signed [DATA_W-1:0] r_coef [5];
    logic [4:0]               r_cv;
    logic [4:0]               r_cf;
    logic                     r_last;
    logic                     r_fin;
    logic signed [DATA_W-1:0] r_max [5];
    logic signed [DATA_W-1:0] r_min [5];
    logic signed [SW-1:0]     r_sum [5];

    logic signed [DATA_W-1:0] w_a1, w_a2, w_a3, w_a4;
    logic signed [DATA_W-1:0] w_d1, w_d2, w_d3, w_d4;
    logic signed [SW-1:0]     w_ext [5];

    // Whole cascade resolves combinationally on the sample that completes each level's pair.
    assign w_a1 = f_avg(r_h1, preprocessed_input);
    assign w_d1 = f_dif(r_h1, preprocessed_input);
    assign w_a2 = f_avg(r_h2, w_a1);
    assign w_d2 = f_dif(r_h2, w_a1);
    assign w_a3 = f_avg(r_h3, w_a2);
    assign w_d3 = f_dif(r_h3, w_a2);
    assign w_a4 = f_avg(r_h4, w_a3);
    assign w_d4 = f_dif(r_h4, w_a3);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_ext[i] = {{7{r_coef[i][DATA_W-1]}}, r_coef[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_h1   <= '0;
            r_h2   <= '0;
            r_h3   <= '0;
            r_h4   <= '0;
            r_cv   <= '0;
            r_cf   <= '0;
            r_last <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            r_cv   <= '0;
            r_last <= 1'b0;
            if (en) begin
                r_cnt <= r_cnt + 7'd1;
                if (!r_cnt[0])           r_h1 <= preprocessed_input;
                if (r_cnt[1:0] == 2'd1)  r_h2 <= w_a1;
                if (r_cnt[2:0] == 3'd3)  r_h3 <= w_a2;
                if (r_cnt[3:0] == 4'd7)  r_h4 <= w_a3;
                r_coef[0] <= w_d1;
                r_coef[1] <= w_d2;
                r_coef[2] <= w_d3;
                r_coef[3] <= w_d4;
                r_coef[4] <= w_a4;
                r_cv[0]   <= r_cnt[0];
                r_cv[1]   <= &r_cnt[1:0];
                r_cv[2]   <= &r_cnt[2:0];
                r_cv[3]   <= &r_cnt[3:0];
                r_cv[4]   <= &r_cnt[3:0];
                r_cf[0]   <= (r_cnt == 7'd1);
                r_cf[1]   <= (r_cnt == 7'd3);
                r_cf[2]   <= (r_cnt == 7'd7);
                r_cf[3]   <= (r_cnt == 7'd15);
                r_cf[4]   <= (r_cnt == 7'd15);
                r_last    <= &r_cnt;
            end
        end
    end

    // The first coefficient of a window overwrites the stats, so no clear is needed between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fin <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_max[i] <= '0;
                r_min[i] <= '0;
                r_sum[i] <= '0;
            end
        end else begin
            r_fin <= r_last;
            for (int i = 0; i < 5; i++) begin
                if (r_cv[i]) begin
                    if (r_cf[i]) begin
                        r_max[i] <= r_coef[i];
                        r_min[i] <= r_coef[i];
                        r_sum[i] <= w_ext[i];
                    end else begin
                        if (r_coef[i] > r_max[i]) r_max[i] <= r_coef[i];
                        if (r_coef[i] < r_min[i]) r_min[i] <= r_coef[i];
                        r_sum[i] <= r_sum[i] + w_ext[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwt_valid      <= 1'b0;
            dwt_gamma_max  <= '0;
            dwt_gamma_min  <= '0;
            dwt_gamma_mean <= '0;
            dwt_gamma_sum  <= '0;
            dwt_beta_max   <= '0;
            dwt_beta_min   <= '0;
            dwt_beta_mean  <= '0;
            dwt_beta_sum   <= '0;
            dwt_alpha_max  <= '0;
            dwt_alpha_min  <= '0;
            dwt_alpha_mean <= '0;
            dwt_alpha_sum  <= '0;
            dwt_theta_max  <= '0;
            dwt_theta_min  <= '0;
            dwt_theta_mean <= '0;
            dwt_theta_sum  <= '0;
            dwt_delta_max  <= '0;
            dwt_delta_min  <= '0;
            dwt_delta_mean <= '0;
            dwt_delta_sum  <= '0;
        end else begin
            dwt_valid <= r_fin;
            if (r_fin) begin
                dwt_gamma_max  <= r_max[0];
                dwt_gamma_min  <= r_min[0];
                dwt_gamma_mean <= DATA_W'(r_sum[0] >>> 6);
                dwt_gamma_sum  <= DATA_W'(r_sum[0]);
                dwt_beta_max   <= r_max[1];
                dwt_beta_min   <= r_min[1];
                dwt_beta_mean  <= DATA_W'(r_sum[1] >>> 5);
                dwt_beta_sum   <= DATA_W'(r_sum[1]);
                dwt_alpha_max  <= r_max[2];
                dwt_alpha_min  <= r_min[2];
                dwt_alpha_mean <= DATA_W'(r_sum[2] >>> 4);
                dwt_alpha_sum  <= DATA_W'(r_sum[2]);
                dwt_theta_max  <= r_max[3];
                dwt_theta_min  <= r_min[3];
                dwt_theta_mean <= DATA_W'(r_sum[3] >>> 3);
                dwt_theta_sum  <= DATA_W'(r_sum[3]);
                dwt_delta_max  <= r_max[4];
                dwt_delta_min  <= r_min[4];
                dwt_delta_mean <= DATA_W'(r_sum[4] >>> 3);
                dwt_delta_sum  <= DATA_W'(r_sum[4]);
            end
        end
    end

endmodule

// File: tb/tb_eeg_dwt_top.sv
// tb/tb_eeg_dwt_top.sv - directed-vector bench for eeg_dwt_top
module tb_eeg_dwt_top;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b0;
    logic signed [31:0] din = '0;
    logic signed [31:0] cur [20];
    logic               dwt_valid;

    eeg_dwt_top #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .preprocessed_input(din),
        .dwt_gamma_max(cur[0]),  .dwt_gamma_min(cur[1]),  .dwt_gamma_mean(cur[2]),  .dwt_gamma_sum(cur[3]),
        .dwt_beta_max(cur[4]),   .dwt_beta_min(cur[5]),   .dwt_beta_mean(cur[6]),   .dwt_beta_sum(cur[7]),
        .dwt_alpha_max(cur[8]),  .dwt_alpha_min(cur[9]),  .dwt_alpha_mean(cur[10]), .dwt_alpha_sum(cur[11]),
        .dwt_theta_max(cur[12]), .dwt_theta_min(cur[13]), .dwt_theta_mean(cur[14]), .dwt_theta_sum(cur[15]),
        .dwt_delta_max(cur[16]), .dwt_delta_min(cur[17]), .dwt_delta_mean(cur[18]), .dwt_delta_sum(cur[19]),
        .dwt_valid(dwt_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 n_pulse  = 0;
    int                 unstable = 0;
    int                 pulse_cyc [8];
    logic signed [31:0] snap [8][20];
    logic signed [31:0] prev [20];
    int                 expv [20];
    string              bn [5] = '{"gamma", "beta", "alpha", "theta", "delta"};
    string              sn [4] = '{"max", "min", "mean", "sum"};

    always @(negedge clk) begin
        if (dwt_valid) begin
            if (n_pulse < 8) begin
                pulse_cyc[n_pulse] = cyc;
                for (int j = 0; j < 20; j++) snap[n_pulse][j] = cur[j];
            end
            n_pulse++;
        end else if (!rst) begin
            for (int j = 0; j < 20; j++) if (cur[j] !== prev[j]) unstable++;
        end
        for (int j = 0; j < 20; j++) prev[j] = cur[j];
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int j = 0; j < 20; j++) expv[j] = 0;
    endtask

    task automatic set_band(input int b, input int mx, input int mn, input int mean, input int sum);
        expv[b*4+0] = mx;
        expv[b*4+1] = mn;
        expv[b*4+2] = mean;
        expv[b*4+3] = sum;
    endtask

    task automatic exp_const();
        clear_exp();
        set_band(4, 100, 100, 100, 800);
    endtask

    task automatic exp_ramp();
        clear_exp();
        set_band(0, -1, -1, -1, -64);
        set_band(1, -1, -1, -1, -32);
        set_band(2, -2, -2, -2, -32);
        set_band(3, -4, -4, -4, -32);
        set_band(4, 119, 7, 63, 504);
    endtask

    task automatic step(input logic e, input logic signed [31:0] x);
        en  = e;
        din = x;
        @(posedge clk);
        #1;
        en  = 1'b0;
    endtask

    function automatic logic signed [31:0] sample(input int kind, input int n);
        if (kind == 0) return 32'sd100;
        if (kind == 1) return (n % 2 == 0) ? 32'sd64 : -32'sd64;
        return 32'(n);
    endfunction

    // Idle cycles drive a junk sample to prove en=0 leaves the state untouched.
    task automatic send_window(input int kind, input bit gaps, input int count, output int e_cyc);
        for (int n = 0; n < count; n++) begin
            if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 32'sd12345);
            step(1'b1, sample(kind, n));
        end
        e_cyc = cyc;
    endtask

    task automatic expect_pulse(input string name, input int idx, input int e_cyc);
        int t = 0;
        while (n_pulse <= idx && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq({name, "_pulse_seen"}, (n_pulse > idx) ? 1 : 0, 1);
        if (n_pulse > idx) begin
            check_eq({name, "_latency"}, pulse_cyc[idx], e_cyc + 2);
            for (int j = 0; j < 20; j++)
                check_eq({name, "_", bn[j/4], "_", sn[j%4]}, snap[idx][j], expv[j]);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check_eq({name, "_valid"}, dwt_valid, 0);
        for (int j = 0; j < 20; j++)
            check_eq({name, "_", bn[j/4], "_", sn[j%4]}, cur[j], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int e1;
        int e2;
        int u0;

        rst = 1'b1;
        repeat (3) step(1'b0, 32'sd0);
        rst = 1'b0;
        check_zero_outputs("reset");
        check_eq("reset_pulses", n_pulse, 0);

        send_window(0, 1'b0, 128, e1);
        exp_const();
        expect_pulse("t1_const", 0, e1);
        repeat (3) step(1'b0, 32'sd0);
        check_eq("t1_pulse_count", n_pulse, 1);

        send_window(1, 1'b0, 128, e1);
        clear_exp();
        set_band(0, 64, 64, 64, 4096);
        expect_pulse("t2_alt", 1, e1);
        repeat (3) step(1'b0, 32'sd0);
        check_eq("t2_pulse_count", n_pulse, 2);

        send_window(2, 1'b0, 128, e1);
        exp_ramp();
        expect_pulse("t3_ramp", 2, e1);
        repeat (3) step(1'b0, 32'sd0);
        check_eq("t3_pulse_count", n_pulse, 3);

        send_window(2, 1'b1, 128, e1);
        expect_pulse("t4_gaps", 3, e1);
        repeat (3) step(1'b0, 32'sd0);
        check_eq("t4_pulse_count", n_pulse, 4);

        send_window(2, 1'b0, 50, e1);
        rst = 1'b1;
        step(1'b0, 32'sd0);
        rst = 1'b0;
        check_zero_outputs("t5_after_rst");
        check_eq("t5_no_pulse", n_pulse, 4);
        send_window(0, 1'b0, 128, e1);
        exp_const();
        expect_pulse("t5_const", 4, e1);
        repeat (3) step(1'b0, 32'sd0);
        check_eq("t5_pulse_count", n_pulse, 5);

        u0 = unstable;
        send_window(2, 1'b0, 128, e1);
        send_window(0, 1'b0, 128, e2);
        exp_ramp();
        expect_pulse("t6_first", 5, e1);
        exp_const();
        expect_pulse("t6_second", 6, e2);
        check_eq("t6_pulse_spacing", pulse_cyc[6] - pulse_cyc[5], 128);
        repeat (3) step(1'b0, 32'sd0);
        check_eq("t6_pulse_count", n_pulse, 7);
        check_eq("t6_output_changes", unstable - u0, 0);

        send_window(2, 1'b0, 128, e1);
        rst = 1'b1;
        step(1'b0, 32'sd0);
        rst = 1'b0;
        repeat (5) step(1'b0, 32'sd0);
        check_eq("t7_rst_kills_pulse", n_pulse, 7);
        check_eq("t7_delta_sum_cleared", cur[19], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
